iomem_pwm: RTL

//  Multi-channel PWM peripheral on the PicoSoC iomem bus; replaces the plain on/off GPIO LED register.

---
 rtl/iomem_pwm_pkg.sv | 29 ++
 rtl/iomem_pwm_if.sv | 19 +
 rtl/iomem_pwm_channel.sv | 55 +++++
 rtl/iomem_pwm.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/iomem_pwm_pkg.sv
// Shared definitions for the iomem PWM peripheral: register map, CTRL/STATUS
// bit positions and the byte-lane write merge helper.
package iomem_pwm_pkg;

    // Register word offsets, i.e. iomem_addr[7:2]
    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_PRESCALE = 6'h01;
    localparam logic [5:0] REG_PERIOD   = 6'h02;
    localparam logic [5:0] REG_STATUS   = 6'h03;
    localparam logic [5:0] REG_DUTY0    = 6'h04;

    localparam int CH_EN_LSB       = 0;
    localparam int INV_LSB         = 8;
    localparam int GBL_EN_BIT      = 31;
    localparam int STATUS_PEND_BIT = 31;

    function automatic logic [31:0] merge_wstrb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iomem_pwm_if.sv
// PicoSoC iomem bus bundle; the CPU side is the master, peripherals are slaves.
interface iomem_pwm_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_pwm_channel.sv
// One PWM channel: double-buffered duty value, compare against the shared
// period counter, polarity select and a registered output.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             duty_we,
    input  logic [WIDTH-1:0] duty_wval,
    input  logic             load,
    input  logic             copy_now,
    input  logic [WIDTH-1:0] counter,
    input  logic             enable,
    input  logic             invert,
    output logic [WIDTH-1:0] duty_shadow,
    output logic             pending,
    output logic             pwm
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    // Shadow/active update and compare; a wrap loads the pre-write shadow
    always_comb begin
        shadow_d = duty_we ? duty_wval : shadow_q;
        active_d = active_q;
        if (copy_now) begin
            active_d = shadow_d;
        end else if (load) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
        pwm_d = (enable && (counter < active_q)) ^ invert;
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_q <= {WIDTH{1'b0}};
            active_q <= {WIDTH{1'b0}};
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign duty_shadow = shadow_q;
    assign pending     = (shadow_q != active_q);
    assign pwm         = pwm_q;

endmodule

// File: rtl/iomem_pwm.sv
// Multi-channel PWM peripheral on the iomem bus: register decode, CTRL,
// prescaler, shared period counter and the PERIOD shadow/active pair.
module iomem_pwm
    import iomem_pwm_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h03,
    parameter int         CHANNELS   = 3,
    parameter int         WIDTH      = 8,
    parameter int         PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    iomem_pwm_if.slave          bus,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                wrap_pulse
);

    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [CHANNELS-1:0]   ch_en_q, ch_en_d;
    logic [CHANNELS-1:0]   inv_q, inv_d;
    logic                  gbl_en_q, gbl_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]      period_sh_q, period_sh_d;
    logic [WIDTH-1:0]      period_act_q, period_act_d;
    logic [WIDTH-1:0]      counter_q, counter_d;
    logic                  wrap_q, wrap_d;

    logic [5:0]            offset;
    logic                  hit, wr;
    logic                  ctrl_we, prescale_we, period_we;
    logic [CHANNELS-1:0]   duty_we;
    logic [WIDTH-1:0]      duty_sh [CHANNELS];
    logic [CHANNELS-1:0]   ch_pend;
    logic                  pending;
    logic                  tick, wrap;
    logic [31:0]           rd_val, wr_val;
    logic                  unused_addr;

    assign offset      = bus.iomem_addr[7:2];
    assign unused_addr = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0]};
    assign hit         = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_ADDR);
    assign wr          = hit && (bus.iomem_wstrb != 4'b0000);
    assign ctrl_we     = wr && (offset == REG_CTRL);
    assign prescale_we = wr && (offset == REG_PRESCALE);
    assign period_we   = wr && (offset == REG_PERIOD);
    assign pending     = (period_sh_q != period_act_q) || (|ch_pend);

    // Read mux; also the base value that partial-strobe writes merge into
    always_comb begin
        rd_val = 32'h0000_0000;
        case (offset)
            REG_CTRL: begin
                rd_val[CH_EN_LSB +: CHANNELS] = ch_en_q;
                rd_val[INV_LSB +: CHANNELS]   = inv_q;
                rd_val[GBL_EN_BIT]            = gbl_en_q;
            end
            REG_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale_q;
            REG_PERIOD:   rd_val[WIDTH-1:0]      = period_sh_q;
            REG_STATUS: begin
                rd_val[WIDTH-1:0]       = counter_q;
                rd_val[STATUS_PEND_BIT] = pending;
            end
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    rd_val[WIDTH-1:0] = rd_val[WIDTH-1:0]
                        | (duty_sh[i] & {WIDTH{offset == (REG_DUTY0 + 6'(i))}});
                end
            end
        endcase
        wr_val = merge_wstrb(rd_val, bus.iomem_wdata, bus.iomem_wstrb);
        for (int i = 0; i < CHANNELS; i++) begin
            duty_we[i] = wr && (offset == (REG_DUTY0 + 6'(i)));
        end
    end

    // Bus response and CTRL/PRESCALE/PERIOD register writes
    always_comb begin
        ready_d     = hit;
        rdata_d     = hit ? rd_val : 32'h0000_0000;
        ch_en_d     = ctrl_we ? wr_val[CH_EN_LSB +: CHANNELS] : ch_en_q;
        inv_d       = ctrl_we ? wr_val[INV_LSB +: CHANNELS] : inv_q;
        gbl_en_d    = ctrl_we ? wr_val[GBL_EN_BIT] : gbl_en_q;
        prescale_d  = prescale_we ? wr_val[PRESCALE_W-1:0] : prescale_q;
        period_sh_d = period_we ? wr_val[WIDTH-1:0] : period_sh_q;
    end

    // Timebase: prescaler, period counter and the wrap-time shadow load
    always_comb begin
        tick         = gbl_en_q && (presc_cnt_q == prescale_q);
        wrap         = tick && (counter_q == period_act_q);
        wrap_d       = wrap;
        presc_cnt_d  = presc_cnt_q;
        counter_d    = counter_q;
        period_act_d = period_act_q;
        if (!gbl_en_q || tick || prescale_we) begin
            presc_cnt_d = {PRESCALE_W{1'b0}};
        end else begin
            presc_cnt_d = presc_cnt_q + PRESCALE_W'(1'b1);
        end
        if (!gbl_en_q || wrap) begin
            counter_d = {WIDTH{1'b0}};
        end else if (tick) begin
            counter_d = counter_q + WIDTH'(1'b1);
        end else begin
            counter_d = counter_q;
        end
        // While stopped, active tracks shadow so the first period is already correct
        if (!gbl_en_q) begin
            period_act_d = period_sh_d;
        end else if (wrap) begin
            period_act_d = period_sh_q;
        end else begin
            period_act_d = period_act_q;
        end
    end

    // Top-level state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q      <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            ch_en_q      <= {CHANNELS{1'b0}};
            inv_q        <= {CHANNELS{1'b0}};
            gbl_en_q     <= 1'b0;
            prescale_q   <= {PRESCALE_W{1'b0}};
            presc_cnt_q  <= {PRESCALE_W{1'b0}};
            period_sh_q  <= {WIDTH{1'b1}};
            period_act_q <= {WIDTH{1'b1}};
            counter_q    <= {WIDTH{1'b0}};
            wrap_q       <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            ch_en_q      <= ch_en_d;
            inv_q        <= inv_d;
            gbl_en_q     <= gbl_en_d;
            prescale_q   <= prescale_d;
            presc_cnt_q  <= presc_cnt_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            counter_q    <= counter_d;
            wrap_q       <= wrap_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .duty_we     (duty_we[gi]),
            .duty_wval   (wr_val[WIDTH-1:0]),
            .load        (wrap),
            .copy_now    (!gbl_en_q),
            .counter     (counter_q),
            .enable      (ch_en_q[gi] && gbl_en_q),
            .invert      (inv_q[gi]),
            .duty_shadow (duty_sh[gi]),
            .pending     (ch_pend[gi]),
            .pwm         (pwm_out[gi])
        );
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign wrap_pulse      = wrap_q;

endmodule
